atomrvcore_mem_arb: RTL and testbench

ATOMRVCORE_MEM_ARB -- requirements
Module: atomrvcore_mem_arb

---
 rtl/atomrvcore_mem_arb_if.sv | 47 ++++
 rtl/atomrvcore_mem_arb.sv | 98 +++++++++
 tb/tb_atomrvcore_mem_arb.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/atomrvcore_mem_arb_if.sv
// Bundles the fetch, data and memory ports of the memory arbiter.
// 'slave' is the arbiter's view; 'master' is the requester/memory side.
interface atomrvcore_mem_arb_if #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 32
);
  logic                   if_req_i;
  logic [ADDRWIDTH-1:0]   if_addr_i;
  logic                   if_gnt_o;
  logic                   if_rvalid_o;
  logic [DATAWIDTH-1:0]   if_rdata_o;

  logic                   d_req_i;
  logic                   d_we_i;
  logic [DATAWIDTH/8-1:0] d_be_i;
  logic [ADDRWIDTH-1:0]   d_addr_i;
  logic [DATAWIDTH-1:0]   d_wdata_i;
  logic                   d_gnt_o;
  logic                   d_rvalid_o;
  logic [DATAWIDTH-1:0]   d_rdata_o;

  logic                   mem_req_o;
  logic                   mem_we_o;
  logic [DATAWIDTH/8-1:0] mem_be_o;
  logic [ADDRWIDTH-1:0]   mem_addr_o;
  logic [DATAWIDTH-1:0]   mem_wdata_o;
  logic                   mem_gnt_i;
  logic [DATAWIDTH-1:0]   mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rdata_i
  );
endinterface

// File: rtl/atomrvcore_mem_arb.sv
// Two-port (fetch/data) arbiter onto a single-ported memory with 1-cycle read latency.
// Data wins conflicts unless fetch has lost STARVE_LIMIT cycles in a row.
module atomrvcore_mem_arb #(
  parameter int DATAWIDTH    = 32,
  parameter int ADDRWIDTH    = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  atomrvcore_mem_arb_if.slave  bus
);
  localparam int BEW = DATAWIDTH / 8;
  localparam int SW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_D    = 2'd2
  } tag_e;

  tag_e                 tag_q, tag_d;
  logic [SW-1:0]        starve_q, starve_d;

  logic                 starve_hit;
  logic                 sel_if, sel_d;
  logic                 if_gnt, d_gnt;
  logic                 mem_we;
  logic [BEW-1:0]       mem_be;
  logic [ADDRWIDTH-1:0] mem_addr;
  logic [DATAWIDTH-1:0] mem_wdata;

  // Selection and grants are purely combinational; reset masks them immediately.
  always_comb begin
    starve_hit = (starve_q == LIMIT);
    sel_if     = bus.if_req_i & (~bus.d_req_i | starve_hit);
    sel_d      = bus.d_req_i & ~sel_if;
    if_gnt     = rst_ni & sel_if & bus.mem_gnt_i;
    d_gnt      = rst_ni & sel_d & bus.mem_gnt_i;

    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (sel_if) begin
      mem_be   = {BEW{1'b1}};
      mem_addr = bus.if_addr_i;
    end else if (sel_d) begin
      mem_we    = bus.d_we_i;
      mem_be    = bus.d_be_i;
      mem_addr  = bus.d_addr_i;
      mem_wdata = bus.d_wdata_i;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req_i || if_gnt) begin
      starve_d = '0;
    end else if (!starve_hit) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Outstanding-read owner: one cycle of memory latency, so the tag lives exactly one cycle.
  always_comb begin
    tag_d = TAG_NONE;
    if (if_gnt) begin
      tag_d = TAG_IF;
    end else if (d_gnt && !bus.d_we_i) begin
      tag_d = TAG_D;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
      tag_q    <= TAG_NONE;
    end else begin
      starve_q <= starve_d;
      tag_q    <= tag_d;
    end
  end

  always_comb begin
    bus.if_gnt_o    = if_gnt;
    bus.d_gnt_o     = d_gnt;
    bus.mem_req_o   = rst_ni & (bus.if_req_i | bus.d_req_i);
    bus.mem_we_o    = mem_we;
    bus.mem_be_o    = mem_be;
    bus.mem_addr_o  = mem_addr;
    bus.mem_wdata_o = mem_wdata;
    bus.if_rvalid_o = (tag_q == TAG_IF);
    bus.d_rvalid_o  = (tag_q == TAG_D);
    bus.if_rdata_o  = (tag_q == TAG_IF) ? bus.mem_rdata_i : '0;
    bus.d_rdata_o   = (tag_q == TAG_D)  ? bus.mem_rdata_i : '0;
  end
endmodule

// File: tb/tb_atomrvcore_mem_arb.sv
// Randomized + directed bench for atomrvcore_mem_arb with a scoreboard of expected read returns.
module tb_atomrvcore_mem_arb;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BW = DW / 8;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  atomrvcore_mem_arb_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus ();

  atomrvcore_mem_arb #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    bit            is_if;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            lost = 0;          // consecutive cycles fetch asked and was refused
  bit            resp_pending = 1'b0;
  logic [DW-1:0] resp_data = '0;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  // One clock cycle: drive at negedge, check combinational outputs, advance reference model.
  task automatic step(input logic ir, input logic [AW-1:0] ia,
                      input logic dr, input logic dwe, input logic [BW-1:0] dbe,
                      input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                      input logic mg, input logic [DW-1:0] rd_next,
                      output bit ig, output bit dg);
    bit fetch_sel, data_sel, ereq;
    @(negedge clk);
    cyc++;
    bus.if_req_i    = ir;
    bus.if_addr_i   = ia;
    bus.d_req_i     = dr;
    bus.d_we_i      = dwe;
    bus.d_be_i      = dbe;
    bus.d_addr_i    = da;
    bus.d_wdata_i   = dwd;
    bus.mem_gnt_i   = mg;
    bus.mem_rdata_i = resp_pending ? resp_data : DW'($urandom());
    resp_pending    = 1'b0;
    #1;
    fetch_sel = ir && (!dr || lost == SL);
    data_sel  = dr && !fetch_sel;
    if (!rst_n) begin
      ig = 1'b0; dg = 1'b0; ereq = 1'b0;
    end else begin
      ig = fetch_sel && mg; dg = data_sel && mg; ereq = ir || dr;
    end
    chk("if_gnt", bus.if_gnt_o, ig);
    chk("d_gnt", bus.d_gnt_o, dg);
    chk("mem_req", bus.mem_req_o, ereq);
    if (ereq)
      chk("mem_payload", {bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o},
          fetch_sel ? {1'b0, {BW{1'b1}}, ia, {DW{1'b0}}} : {dwe, dbe, da, dwd});
    if (ig || (dg && !dwe)) begin
      sb.push_back('{ig, rd_next, cyc + 1});
      resp_pending = 1'b1;
      resp_data    = rd_next;
    end
    if (!rst_n || !ir || ig) lost = 0;
    else if (lost < SL) lost++;
  endtask

  task automatic idle();
    bit ig, dg;
    step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b1, DW'($urandom()), ig, dg);
  endtask

  // Async reset asserted mid-cycle; an outstanding read must vanish and all outputs go quiet.
  task automatic do_reset();
    bit ig, dg;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb.delete();
    resp_pending = 1'b0;
    lost = 0;
    #1;
    chk("rst_outputs", {bus.if_gnt_o, bus.d_gnt_o, bus.mem_req_o, bus.if_rvalid_o,
                        bus.d_rvalid_o, bus.if_rdata_o, bus.d_rdata_o}, '0);
    repeat (2) step(1'b1, 32'h80, 1'b1, 1'b0, '1, 32'h300, '0, 1'b1, DW'($urandom()), ig, dg);
    idle();
    rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever a read return is presented.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (bus.if_rvalid_o || bus.d_rvalid_o) begin
        if (sb.size() == 0) begin
          chk("spurious_rvalid", {bus.if_rvalid_o, bus.d_rvalid_o}, 2'b00);
        end else begin
          e = sb.pop_front();
          chk("rvalid_owner", {bus.if_rvalid_o, bus.d_rvalid_o}, e.is_if ? 2'b10 : 2'b01);
          chk("rvalid_cycle", cyc, e.due);
          chk("rdata", e.is_if ? bus.if_rdata_o : bus.d_rdata_o, e.data);
          chk("other_rdata", e.is_if ? bus.d_rdata_o : bus.if_rdata_o, '0);
        end
      end else begin
        chk("idle_rdata", {bus.if_rdata_o, bus.d_rdata_o}, '0);
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          chk("missing_rvalid", {bus.if_rvalid_o, bus.d_rvalid_o}, sb[0].is_if ? 2'b10 : 2'b01);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    bit            ig, dg;
    logic          ir, dr, dwe;
    logic [AW-1:0] ia, da;
    logic [BW-1:0] dbe;
    logic [DW-1:0] dwd;

    bus.if_req_i = 1'b0; bus.if_addr_i = '0;
    bus.d_req_i = 1'b0; bus.d_we_i = 1'b0; bus.d_be_i = '0; bus.d_addr_i = '0; bus.d_wdata_i = '0;
    bus.mem_gnt_i = 1'b0; bus.mem_rdata_i = '0;

    // Reset held with requests present: nothing may be granted
    repeat (2) step(1'b1, 32'h10, 1'b1, 1'b0, '1, 32'h20, '0, 1'b1, 32'h1, ig, dg);
    idle();
    rst_n = 1'b1;

    // Fetch only, granted on the first edge after release
    step(1'b1, 32'h0000_0010, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'h0000_0093, ig, dg);
    idle();

    // Continuous conflict: data x4, fetch, data
    repeat (6) step(1'b1, 32'h40, 1'b1, 1'b0, '1, 32'h200, '0, 1'b1, DW'($urandom()), ig, dg);
    idle();

    // Store: no read return
    step(1'b0, '0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF, 1'b1, DW'($urandom()), ig, dg);
    idle();

    // Backpressure for 3 cycles, then data, then starved fetch
    repeat (3) step(1'b1, 32'h44, 1'b1, 1'b0, '1, 32'h204, '0, 1'b0, DW'($urandom()), ig, dg);
    repeat (2) step(1'b1, 32'h44, 1'b1, 1'b0, '1, 32'h204, '0, 1'b1, DW'($urandom()), ig, dg);
    idle();

    // Interleave: data read then fetch read back to back
    step(1'b0, '0, 1'b1, 1'b0, '1, 32'h208, '0, 1'b1, 32'hAAAA_0001, ig, dg);
    step(1'b1, 32'h48, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'hBBBB_0002, ig, dg);
    idle();

    // Reset with a fetch read in flight
    step(1'b1, 32'h4C, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'hCCCC_0003, ig, dg);
    do_reset();

    // Random traffic with requesters holding until granted
    ir = 1'b0; dr = 1'b0; ia = '0; da = '0; dbe = '0; dwd = '0; dwe = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 500 == 250) do_reset();
      if (!ir) begin
        ir = ($urandom_range(0, 3) != 0);
        ia = AW'($urandom());
      end
      if (!dr) begin
        dr  = ($urandom_range(0, 2) != 0);
        dwe = 1'($urandom_range(0, 1));
        dbe = BW'($urandom());
        da  = AW'($urandom());
        dwd = DW'($urandom());
      end
      step(ir, ia, dr, dwe, dbe, da, dwd, ($urandom_range(0, 4) != 0), DW'($urandom()), ig, dg);
      if (ig) ir = 1'b0;
      if (dg) dr = 1'b0;
    end

    repeat (3) idle();
    chk("queue_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
